// File: rtl/xbus_ram_bridge_if.sv
// Bus bundles for the Xbus DRAM bridge: the Xbus slave port and the SDRAM controller handshake.
interface xbus_if;
  logic [21:0] addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        req;
  logic        write;
  logic        ack;
  logic        decode;

  modport master (output addr, datain, req, write, input dataout, ack, decode);
  modport slave  (input addr, datain, req, write, output dataout, ack, decode);
endinterface

interface sdram_if;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_data_in;
  logic [31:0] sdram_data_out;
  logic        sdram_req;
  logic        sdram_ready;
  logic        sdram_write;
  logic        sdram_done;

  modport master (output sdram_addr, sdram_data_out, sdram_req, sdram_write,
                  input  sdram_data_in, sdram_ready, sdram_done);
  modport slave  (input  sdram_addr, sdram_data_out, sdram_req, sdram_write,
                  output sdram_data_in, sdram_ready, sdram_done);
endinterface

// File: rtl/xbus_ram_bridge.sv
// Xbus slave turning DRAM-window requests into one SDRAM controller transaction each.
// Optional XBUS_RAM_WRITE_POST_EN: writes ack on sdram_ready; their done retires in the background.
module xbus_ram_bridge #(
  parameter logic [21:0] DRAM_TOP = 22'o17000000
) (
  input  logic     clk,
  input  logic     reset,
  xbus_if.slave    xbus,
  sdram_if.master  sdram
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [21:0] r_sdram_addr;
  logic [31:0] r_sdram_data_out;
  logic [31:0] r_dataout;
  logic        r_sdram_write;

  logic w_decode;
  logic w_start;
  logic w_req_allowed;
  logic w_accept;
  logic w_posted;
  logic w_capture;
  logic w_sdram_req;
  logic w_ack;

  assign w_decode = (xbus.addr < DRAM_TOP);
  assign w_start  = (r_state == S_IDLE) && xbus.req && w_decode;

`ifdef XBUS_RAM_WRITE_POST_EN
  // A posted write still owes the controller a done; hold off the next request until it lands.
  logic r_post_pending;

  assign w_req_allowed = !r_post_pending;
  assign w_posted      = r_sdram_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_post_pending <= 1'b0;
    else if (w_accept && r_sdram_write && !sdram.sdram_done)
      r_post_pending <= 1'b1;
    else if (sdram.sdram_done)
      r_post_pending <= 1'b0;
  end
`else
  assign w_req_allowed = 1'b1;
  assign w_posted      = 1'b0;
`endif

  assign w_accept  = (r_state == S_REQ) && w_req_allowed && sdram.sdram_ready;
  assign w_capture = !r_sdram_write && sdram.sdram_done &&
                     (w_accept || (r_state == S_WAIT));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next_state = S_REQ;
      S_REQ: begin
        // ready with done in the same cycle skips WAIT entirely
        if (w_accept)
          w_next_state = (sdram.sdram_done || w_posted) ? S_ACK : S_WAIT;
      end
      S_WAIT: if (sdram.sdram_done) w_next_state = S_ACK;
      S_ACK:  w_next_state = xbus.req ? S_HOLD : S_IDLE;
      S_HOLD: if (!xbus.req) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_sdram_req = 1'b0;
    w_ack       = 1'b0;
    unique case (r_state)
      S_REQ:   w_sdram_req = w_req_allowed;
      S_ACK:   w_ack       = 1'b1;
      default: ;
    endcase
  end

  // Request fields are latched once in IDLE so the SDRAM op sees stable values even if the master changes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sdram_addr     <= '0;
      r_sdram_data_out <= '0;
      r_sdram_write    <= 1'b0;
      r_dataout        <= '0;
    end else begin
      if (w_start) begin
        r_sdram_addr     <= xbus.addr;
        r_sdram_data_out <= xbus.datain;
        r_sdram_write    <= xbus.write;
      end
      if (w_capture)
        r_dataout <= sdram.sdram_data_in;
    end
  end

  assign xbus.decode          = w_decode;
  assign xbus.ack             = w_ack;
  assign xbus.dataout         = r_dataout;
  assign sdram.sdram_req      = w_sdram_req;
  assign sdram.sdram_write    = r_sdram_write;
  assign sdram.sdram_addr     = r_sdram_addr;
  assign sdram.sdram_data_out = r_sdram_data_out;

endmodule

// File: tb/tb_xbus_ram_bridge.sv
// Directed bench for xbus_ram_bridge: reset, decode edges, reads, writes, hold-off and mid-op reset.
module tb_xbus_ram_bridge;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   ack_count   = 0;
  int   sreq_count  = 0;
  int   a0;
  int   s0;

`ifdef XBUS_RAM_WRITE_POST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  xbus_if  xb ();
  sdram_if sd ();

  xbus_ram_bridge dut (
    .clk   (clk),
    .reset (reset),
    .xbus  (xb),
    .sdram (sd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (xb.ack === 1'b1)       ack_count++;
    if (sd.sdram_req === 1'b1) sreq_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Controller answers ready one cycle after seeing sdram_req, then done one cycle later
  // (or both together when same is set); the master scrambles its inputs mid-op.
  task automatic run_op(input logic [21:0] a, input logic [31:0] wd, input logic w,
                        input logic [31:0] rd, input bit same);
    int n;
    xb.addr = a; xb.datain = wd; xb.write = w; xb.req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (sd.sdram_req !== 1'b1 && n < 10);
    check("sreq_rise", sd.sdram_req, 1);
    check("swrite", sd.sdram_write, w);
    check("saddr", sd.sdram_addr, a);
    if (w) check("sdata_out", sd.sdram_data_out, wd);
    xb.addr = ~a; xb.datain = ~wd; xb.write = ~w;
    tick();
    check("sreq_held", sd.sdram_req, 1);
    sd.sdram_ready = 1'b1;
    if (same) begin sd.sdram_done = 1'b1; sd.sdram_data_in = rd; end
    tick();
    sd.sdram_ready = 1'b0; sd.sdram_done = 1'b0;
    check("saddr_stable", sd.sdram_addr, a);
    check("swrite_stable", sd.sdram_write, w);
    if (!same && !(POSTED && w)) begin
      check("sreq_drop", sd.sdram_req, 0);
      check("ack_early", xb.ack, 0);
      sd.sdram_done = 1'b1; sd.sdram_data_in = rd;
      tick();
      sd.sdram_done = 1'b0;
    end
    check("ack", xb.ack, 1);
    if (!w) check("dataout", xb.dataout, rd);
    if (POSTED && w && !same) begin
      sd.sdram_done = 1'b1;
      tick();
      sd.sdram_done = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    xb.addr = '0; xb.datain = '0; xb.req = 1'b0; xb.write = 1'b0;
    sd.sdram_data_in = '0; sd.sdram_ready = 1'b0; sd.sdram_done = 1'b0;
    repeat (3) tick();
    check("rst_ack", xb.ack, 0);
    check("rst_sreq", sd.sdram_req, 0);
    check("rst_swrite", sd.sdram_write, 0);
    check("rst_dataout", xb.dataout, 0);
    check("rst_saddr", sd.sdram_addr, 0);
    check("rst_sdata_out", sd.sdram_data_out, 0);
    reset = 1'b0;
    tick();

    // decode is combinational and independent of req
    xb.addr = 22'o16777777; #1 check("decode_top_in", xb.decode, 1);
    xb.addr = 22'o17000000; #1 check("decode_top_out", xb.decode, 0);
    xb.addr = 22'o00000000; #1 check("decode_zero", xb.decode, 1);
    tick();

    // read with one-cycle ready and done
    a0 = ack_count;
    run_op(22'o00001234, 32'h0000_0000, 1'b0, 32'hDEADBEEF, 1'b0);
    xb.req = 1'b0;
    tick();
    check("read_ack_one_cycle", xb.ack, 0);
    check("read_ack_pulses", ack_count - a0, 1);
    check("read_dataout_hold", xb.dataout, 32'hDEADBEEF);

    // write at the top of the window; dataout keeps the last read value
    a0 = ack_count;
    run_op(22'o16777777, 32'h12345678, 1'b1, 32'hCAFEF00D, 1'b0);
    xb.req = 1'b0;
    tick();
    check("write_ack_pulses", ack_count - a0, 1);
    check("write_dataout_kept", xb.dataout, 32'hDEADBEEF);

    // ready and done in the same cycle
    run_op(22'o00000777, 32'h0000_0000, 1'b0, 32'hA5A50F0F, 1'b1);
    xb.req = 1'b0;
    tick();
    check("same_cycle_dataout", xb.dataout, 32'hA5A50F0F);

    // req held after ack: no second transaction until req drops
    a0 = ack_count;
    run_op(22'o00000042, 32'h0000_0000, 1'b0, 32'h0BADF00D, 1'b0);
    s0 = sreq_count;
    repeat (5) tick();
    check("hold_no_sreq", sreq_count - s0, 0);
    check("hold_one_ack", ack_count - a0, 1);
    xb.req = 1'b0;
    tick();
    run_op(22'o00000043, 32'h0000_0000, 1'b0, 32'h13579BDF, 1'b0);
    xb.req = 1'b0;
    tick();
    check("after_hold_ack_pulses", ack_count - a0, 2);

    // request outside the DRAM window is ignored
    a0 = ack_count; s0 = sreq_count;
    xb.addr = 22'o17377770; xb.write = 1'b0; xb.req = 1'b1;
    #1 check("miss_decode", xb.decode, 0);
    repeat (40) tick();
    check("miss_no_sreq", sreq_count - s0, 0);
    check("miss_no_ack", ack_count - a0, 0);
    xb.req = 1'b0;
    tick();

    // reset asserted while waiting for done
    xb.addr = 22'o00000100; xb.write = 1'b0; xb.req = 1'b1;
    tick();
    tick();
    sd.sdram_ready = 1'b1;
    tick();
    sd.sdram_ready = 1'b0;
    check("wait_sreq_low", sd.sdram_req, 0);
    reset = 1'b1;
    #1;
    check("midop_rst_sreq", sd.sdram_req, 0);
    check("midop_rst_ack", xb.ack, 0);
    check("midop_rst_dataout", xb.dataout, 0);
    xb.req = 1'b0;
    tick();
    reset = 1'b0;
    tick();

`ifdef XBUS_RAM_WRITE_POST_EN
    // posted write acks on ready; the next request stalls until its done arrives
    xb.addr = 22'o00000200; xb.datain = 32'h55AA55AA; xb.write = 1'b1; xb.req = 1'b1;
    tick();
    tick();
    sd.sdram_ready = 1'b1;
    tick();
    sd.sdram_ready = 1'b0;
    check("post_ack_before_done", xb.ack, 1);
    xb.req = 1'b0;
    tick();
    xb.addr = 22'o00000300; xb.write = 1'b0; xb.req = 1'b1;
    tick();
    check("post_stall_sreq", sd.sdram_req, 0);
    tick();
    check("post_stall_sreq2", sd.sdram_req, 0);
    sd.sdram_done = 1'b1;
    tick();
    sd.sdram_done = 1'b0;
    check("post_release_sreq", sd.sdram_req, 1);
    tick();
    sd.sdram_ready = 1'b1; sd.sdram_done = 1'b1; sd.sdram_data_in = 32'h00000077;
    tick();
    sd.sdram_ready = 1'b0; sd.sdram_done = 1'b0;
    check("post_read_ack", xb.ack, 1);
    check("post_read_data", xb.dataout, 32'h00000077);
    xb.req = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
